// File: rtl/axi_addr_route_stage.sv
// Registered address-channel router for one crossbar master port.
// Decodes AW/AR addresses to a slave index and enforces single-ID ordering.
module axi_addr_route_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int SLAVES = 2,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE [SLAVES] =
    '{'h0000_0000, 'h1000_0000},
  parameter logic [ADDR_WIDTH-1:0] ADDR_END [SLAVES] =
    '{'h0fff_ffff, 'h1fff_ffff},
  parameter int MAX_OUTSTANDING = 4,
  localparam int DEST_W = $clog2(SLAVES + 1),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DEST_W-1:0]     m_dest,
  output logic                  m_decerr,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  cpl_valid,
  output logic [CNT_W-1:0]      out_cnt,
  output logic                  busy
);

  logic [DEST_W-1:0] dec_dest;
  logic              dec_err;
  logic [DEST_W-1:0] cur_dest;
  logic              ok;
  logic              room;
  logic              accept;
  logic              cpl_take;

  // Region decode; scanning downwards lets the lowest hit index win.
  always_comb begin
    dec_dest = DEST_W'(SLAVES);
    dec_err  = 1'b1;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if (s_addr >= ADDR_BASE[i] &&
          s_addr <= ADDR_END[i]) begin
        dec_dest = DEST_W'(i);
        dec_err  = 1'b0;
      end
    end
  end

  // Ordering gate: same slave with room, or nothing in flight.
  always_comb begin
    room     = out_cnt < CNT_W'(MAX_OUTSTANDING);
    ok       = (out_cnt == '0) ||
               (dec_dest == cur_dest && room);
    s_ready  = ok && (!m_valid || m_ready);
    accept   = s_valid && s_ready;
    cpl_take = cpl_valid && (out_cnt != '0);
    busy     = out_cnt != '0;
  end

  // Output register: load on accept, hold while stalled.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      m_valid  <= 1'b0;
      m_addr   <= '0;
      m_dest   <= '0;
      m_decerr <= 1'b0;
    end else if (accept) begin
      m_valid  <= 1'b1;
      m_addr   <= s_addr;
      m_dest   <= dec_dest;
      m_decerr <= dec_err;
    end else if (m_ready) begin
      m_valid  <= 1'b0;
    end
  end

  // Destination of the most recently accepted request.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cur_dest <= '0;
    end else if (accept) begin
      cur_dest <= dec_dest;
    end
  end

  // Outstanding counter; completions at zero are dropped.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      out_cnt <= '0;
    end else if (accept && !cpl_take) begin
      out_cnt <= out_cnt + CNT_W'(1);
    end else if (!accept && cpl_take) begin
      out_cnt <= out_cnt - CNT_W'(1);
    end
  end

endmodule
